// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one byte-serial uplink among N packet sources.
// Optional: define FRAME_ARBITER_TAG_EN to send a tag byte 8'hA0|owner ahead of each frame.
module frame_arbiter #(
  parameter int N         = 2,
  parameter int FRAME_LEN = 20,
  parameter int TIMEOUT   = 1023
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [N-1:0]   i_SrcAvail,
  input  logic [8*N-1:0] i_SrcDataVal,
  input  logic [N-1:0]   i_SrcDataReady,
  output logic [N-1:0]   o_SrcDataNext,
  input  logic           i_TxNext,
  output logic [7:0]     o_TxDataVal,
  output logic           o_TxDataReady,
  output logic [N-1:0]   o_Grant,
  output logic           o_Stall
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [7:0]       LEN     = 8'(FRAME_LEN);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_TAG  = 5'b00010,
    S_REQ  = 5'b00100,
    S_WAIT = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_gidx;
  logic [N-1:0]     r_grant;
  logic [IDX_W-1:0] r_ptr;
  logic [7:0]       r_count;
  logic [WD_W-1:0]  r_wdog;
  logic [N-1:0]     r_srcNext;
  logic [7:0]       r_txVal;
  logic             r_txRdy;
  logic             r_stall;

  state_t           w_stateNxt;
  logic [IDX_W-1:0] w_gidxNxt;
  logic [N-1:0]     w_grantNxt;
  logic [IDX_W-1:0] w_ptrNxt;
  logic [7:0]       w_countNxt;
  logic [WD_W-1:0]  w_wdogNxt;
  logic [N-1:0]     w_srcNextNxt;
  logic [7:0]       w_txValNxt;
  logic             w_txRdyNxt;
  logic             w_stallNxt;

  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_cand;
  logic [N-1:0]     w_pickOH;
  logic [7:0]       w_srcByte;
  logic             w_srcRdy;

  // Round-robin search starting just above the last owner, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_pick   = r_ptr;
    w_cand   = r_ptr;
    w_pickOH = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N);
      if (!w_found && i_SrcAvail[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      w_pickOH[i] = (w_pick == IDX_W'(i));
    end
  end

  always_comb begin
    w_srcByte = 8'h00;
    w_srcRdy  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_srcByte = i_SrcDataVal[8*i +: 8];
        w_srcRdy  = i_SrcDataReady[i];
      end
    end
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_gidxNxt    = r_gidx;
    w_grantNxt   = r_grant;
    w_ptrNxt     = r_ptr;
    w_countNxt   = r_count;
    w_wdogNxt    = r_wdog;
    w_srcNextNxt = '0;
    w_txValNxt   = r_txVal;
    w_txRdyNxt   = 1'b0;
    w_stallNxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gidxNxt  = w_pick;
          w_grantNxt = w_pickOH;
          w_countNxt = 8'd0;
`ifdef FRAME_ARBITER_TAG_EN
          w_stateNxt = S_TAG;
`else
          w_stateNxt = S_REQ;
`endif
        end
      end
`ifdef FRAME_ARBITER_TAG_EN
      S_TAG: begin
        if (i_TxNext) begin
          w_txValNxt = 8'hA0 | 8'(r_gidx);
          w_txRdyNxt = 1'b1;
          w_stateNxt = S_REQ;
        end
      end
`endif
      S_REQ: begin
        if (r_count >= LEN) begin
          w_stateNxt = S_DONE;
        end else if (i_TxNext) begin
          w_srcNextNxt = r_grant;
          w_wdogNxt    = '0;
          w_stateNxt   = S_WAIT;
        end
      end
      // A byte arriving on the expiry cycle still counts; the stall is suppressed.
      S_WAIT: begin
        if (w_srcRdy) begin
          w_txValNxt = w_srcByte;
          w_txRdyNxt = 1'b1;
          w_countNxt = r_count + 8'd1;
          w_stateNxt = (r_count + 8'd1 < LEN) ? S_REQ : S_DONE;
        end else if (r_wdog == WD_LAST) begin
          w_stallNxt = 1'b1;
          w_stateNxt = S_DONE;
        end else if (r_wdog != WD_MAX) begin
          w_wdogNxt = r_wdog + 1'b1;
        end
      end
      S_DONE: begin
        w_grantNxt = '0;
        w_ptrNxt   = r_gidx;
        w_stateNxt = S_IDLE;
      end
      default: begin
        w_grantNxt = '0;
        w_stateNxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ptr     <= PTR_RST;
      r_count   <= 8'd0;
      r_wdog    <= '0;
      r_srcNext <= '0;
      r_txVal   <= 8'h00;
      r_txRdy   <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_gidx    <= w_gidxNxt;
      r_grant   <= w_grantNxt;
      r_ptr     <= w_ptrNxt;
      r_count   <= w_countNxt;
      r_wdog    <= w_wdogNxt;
      r_srcNext <= w_srcNextNxt;
      r_txVal   <= w_txValNxt;
      r_txRdy   <= w_txRdyNxt;
      r_stall   <= w_stallNxt;
    end
  end

  assign o_SrcDataNext = r_srcNext;
  assign o_TxDataVal   = r_txVal;
  assign o_TxDataReady = r_txRdy;
  assign o_Grant       = r_grant;
  assign o_Stall       = r_stall;

endmodule

// File: doc/frame_arbiter.md
Name: frame_arbiter

Overview:
- Shares one byte-serial uplink (UART or other transmitter using the DataNext/DataReady byte handshake) between N packet-builder sources.
- Grants are frame-granular and round-robin. A granted source owns the uplink until FRAME_LEN bytes have passed or a watchdog expires.
- Sits between the per-channel packet builders and the single serial handler.

Parameters:
- N, 2, number of sources (2..4).
- FRAME_LEN, 20, bytes per frame (4 sync + 16 payload); 1..255.
- TIMEOUT, 1023, max cycles waiting for a source byte before grant is revoked; 1..65535.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- SrcAvail  in  N  level; source i has a frame pending.
- SrcDataVal  in  8*N  byte from source i, bits [8i+7:8i].
- SrcDataReady  in  N  one-cycle pulse; SrcDataVal[i] is valid.
- SrcDataNext  out  N  one-cycle request pulse to the granted source; registered.
- TxNext  in  1  level; uplink can accept a byte.
- TxDataVal  out  8  byte to uplink; registered.
- TxDataReady  out  1  one-cycle pulse; TxDataVal valid.
- Grant  out  N  one-hot current owner; 0 when idle.
- Stall  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (rstn low, async):
  - SrcDataNext=0, TxDataVal=0, TxDataReady=0, Grant=0, Stall=0.
  - State=IDLE, byte count=0, watchdog=0.
  - RR pointer=N-1, so source 0 wins first.
  - Reset mid-frame abandons the frame immediately; no further pulses are issued.
- States (one-hot):
  - IDLE: if SrcAvail!=0, pick the first set bit searching from pointer+1 upward, with wrap. Set Grant, count=0, go to REQ. Arbitration takes 1 cycle.
  - REQ: when TxNext=1 and count<FRAME_LEN, pulse SrcDataNext[g] for exactly 1 cycle, clear watchdog, go to WAIT. If TxNext=0, hold in REQ indefinitely; the watchdog does not run.
  - WAIT: watchdog increments each cycle.
    - On SrcDataReady[g]: next cycle TxDataVal=SrcDataVal[g] and TxDataReady=1 (latency 1), count+1. Go to REQ if count+1<FRAME_LEN, else DONE.
    - SrcDataReady on non-granted bits is ignored.
    - If the watchdog reaches TIMEOUT without a ready: pulse Stall, go to DONE. Count stays short; the partial frame is not padded.
    - Ready and timeout in the same cycle: ready wins, Stall is not pulsed.
  - DONE: Grant=0, pointer=g, go to IDLE. One dead cycle between frames.
- At most one byte request outstanding at any time.
- SrcAvail deasserting mid-frame is ignored; grant release happens only by count or timeout.
- Count width is 8 bits; the watchdog counter is sized to hold TIMEOUT and saturates.
- SrcDataNext, TxDataReady and Stall are never high for 2 consecutive cycles.

Optional Feature:
- Macro: FRAME_ARBITER_TAG_EN.
- Enabled:
  - Add a TAG state between IDLE and REQ.
  - When TxNext=1, emit one byte 8'hA0|g with a TxDataReady pulse before the first source request.
  - The tag does not count toward FRAME_LEN.
- Disabled: IDLE goes directly to REQ; no tag byte appears.

Test Plan:
- Single source: SrcAvail=2'b01, TxNext=1; source answers each SrcDataNext after 2 cycles with bytes FF,FF,FF,7F,00..0F. Required: exactly 20 TxDataReady pulses with identical values in order, Grant=01 throughout, then Grant=00.
- Fairness: SrcAvail=2'b11 held. Required: grant order 0,1,0,1 over 4 frames; each frame contains 20 bytes from only the granted source.
- Backpressure: drop TxNext for 50 cycles mid-frame. Required: no SrcDataNext during the gap, no Stall; the frame completes with 20 bytes after TxNext returns.
- Timeout (TIMEOUT=15): source 0 stops answering after byte 5. Required: Stall pulses once 15 cycles after the 6th request, Grant falls, and source 1 is granted next.
- Reset: assert rstn low during byte 10. Required: all outputs 0 asynchronously. After release with SrcAvail=11, source 0 is granted first.
- With FRAME_ARBITER_TAG_EN: source 1 frame. Required: 21 TxDataReady pulses, the first being 8'hA1.
